// File: rtl/datapath_mc_if.sv
// datapath_mc_if -- operation request / result bundle for datapath_mc.
//   master : requester side (drives OP_VALID, operation fields and enables;
//            observes OP_READY, ACC_OUT, FLAG_Z, FLAG_C, DONE)
//   slave  : datapath side (the opposite directions)
// Parameter WIDTH must match the WIDTH of the attached datapath_mc.
interface datapath_mc_if #(
   parameter int WIDTH = 8
);
   logic             OP_VALID;
   logic             OP_READY;
   logic [3:0]       ALU_OP;
   logic [1:0]       IN_B_SEL;
   logic [WIDTH-1:0] IMM;
   logic [3:0]       REG_SEL;
   logic             EN_REG_F;
   logic             EN_D_MEM;
   logic             EN_ACC;
   logic [WIDTH-1:0] D_MEM_ADDR;
   logic             D_MEM_ADDR_MODE;
   logic [WIDTH-1:0] ACC_OUT;
   logic             FLAG_Z;
   logic             FLAG_C;
   logic             DONE;

   modport master (
      output OP_VALID, ALU_OP, IN_B_SEL, IMM, REG_SEL,
             EN_REG_F, EN_D_MEM, EN_ACC, D_MEM_ADDR, D_MEM_ADDR_MODE,
      input  OP_READY, ACC_OUT, FLAG_Z, FLAG_C, DONE
   );

   modport slave (
      input  OP_VALID, ALU_OP, IN_B_SEL, IMM, REG_SEL,
             EN_REG_F, EN_D_MEM, EN_ACC, D_MEM_ADDR, D_MEM_ADDR_MODE,
      output OP_READY, ACC_OUT, FLAG_Z, FLAG_C, DONE
   );
endinterface

// File: rtl/datapath_mc.sv
// datapath_mc -- multi-cycle accumulator datapath with register file and
// synchronous data memory.
//
// Ports:
//   CLK      clock, all state changes on the rising edge
//   RST_N    synchronous active-low reset (memory contents are kept)
//   bus      datapath_mc_if.slave: operation request (OP_VALID/OP_READY),
//            ALU_OP, IN_B_SEL, IMM, REG_SEL, commit enables, memory
//            address/mode; results ACC_OUT, FLAG_Z, FLAG_C, DONE
//   PORT_IN  (only with DATAPATH_MC_PORT_EN) value read from register
//            REG_COUNT-1
//   PORT_OUT (only with DATAPATH_MC_PORT_EN) last value written to register
//            REG_COUNT-1, reset 0
//
// Optional feature macro: DATAPATH_MC_PORT_EN maps register REG_COUNT-1 onto
// the PORT_IN/PORT_OUT pins; without it that register is ordinary.
//
// Flow: IDLE accepts an operation and captures every input. Memory-operand
// operations wait MEM_LAT cycles in MEM_WAIT; EXEC then commits on its
// closing edge and returns to IDLE.
module datapath_mc #(
   parameter int WIDTH     = 8,
   parameter int REG_COUNT = 8,
   parameter int MEM_AW    = 8,
   parameter int MEM_LAT   = 1
) (
   input logic         CLK,
   input logic         RST_N,
   datapath_mc_if.slave bus
`ifdef DATAPATH_MC_PORT_EN
   ,
   input  logic [WIDTH-1:0] PORT_IN,
   output logic [WIDTH-1:0] PORT_OUT
`endif
);

   localparam int         RW        = (REG_COUNT > 2) ? $clog2(REG_COUNT) : 1;
   localparam logic [4:0] REG_LIMIT = 5'(REG_COUNT);
   localparam logic [3:0] REG_LAST  = 4'(REG_COUNT - 1);
   localparam logic [2:0] WAIT_LOAD = (MEM_LAT > 0) ? 3'(MEM_LAT - 1) : 3'd0;
   localparam int         DEPTH     = 2 ** MEM_AW;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MEM_WAIT,
      ST_EXEC
   } state_t;

   typedef enum logic [3:0] {
      ALU_PASS = 4'd0,
      ALU_ADD  = 4'd1,
      ALU_SUB  = 4'd2,
      ALU_AND  = 4'd3,
      ALU_OR   = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_NOT  = 4'd6,
      ALU_SHL  = 4'd7,
      ALU_SHR  = 4'd8
   } alu_op_t;

   state_t state, state_nxt;
   logic [2:0] wait_cnt;
   logic       op_ready;
   logic       done;
   logic       accept;
   logic       commit;

   // architectural state
   logic [WIDTH-1:0] acc;
   logic             flag_z;
   logic             flag_c;
   logic [WIDTH-1:0] regs [REG_COUNT];
   logic [WIDTH-1:0] mem  [DEPTH];
   logic [WIDTH-1:0] mem_rd;

   // operation captured on the accepting edge
   logic [3:0]        op_q;
   logic              b_mem_q;
   logic [WIDTH-1:0]  opnd_q;
   logic [3:0]        rsel_q;
   logic              en_reg_q;
   logic              en_mem_q;
   logic              en_acc_q;
   logic [MEM_AW-1:0] addr_q;

   // input-side decode
   logic [WIDTH-1:0]        reg_rd;
   logic [MEM_AW+WIDTH-1:0] addr_ext;
   logic [MEM_AW-1:0]       addr_in;

   // ALU
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_res;
   logic [WIDTH:0]   alu_wide;
   logic             alu_c;
   logic             alu_c_upd;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state    <= ST_IDLE;
         wait_cnt <= WAIT_LOAD;
      end else begin
         state <= state_nxt;
         if (state == ST_MEM_WAIT) begin
            wait_cnt <= wait_cnt - 3'd1;
         end else begin
            wait_cnt <= WAIT_LOAD;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (bus.IN_B_SEL[1] && (MEM_LAT > 0)) begin
                  state_nxt = ST_MEM_WAIT;
               end else begin
                  state_nxt = ST_EXEC;
               end
            end
         end
         ST_MEM_WAIT: begin
            if (wait_cnt == 3'd0) begin
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      op_ready = (state == ST_IDLE);
      done     = (state == ST_EXEC);
   end

   assign accept = bus.OP_VALID && op_ready;
   assign commit = RST_N && (state == ST_EXEC);

   // ------------------------------------------------------- input decode
   always_comb begin
      reg_rd = '0;
      if ({1'b0, bus.REG_SEL} < REG_LIMIT) begin
         reg_rd = regs[bus.REG_SEL[RW-1:0]];
      end
`ifdef DATAPATH_MC_PORT_EN
      if (bus.REG_SEL == REG_LAST) begin
         reg_rd = PORT_IN;
      end
`endif
   end

   // Zero-extend before slicing so the same expression serves MEM_AW both
   // narrower (wrap-around) and wider than WIDTH.
   always_comb begin
      addr_ext = {{MEM_AW{1'b0}}, (bus.D_MEM_ADDR_MODE ? reg_rd : bus.D_MEM_ADDR)};
      addr_in  = addr_ext[MEM_AW-1:0];
   end

   // Register operand and memory address are both resolved at accept time;
   // registers cannot change before EXEC, and PORT_IN must be sampled then.
   always_ff @(posedge CLK) begin
      if (accept) begin
         op_q     <= bus.ALU_OP;
         b_mem_q  <= bus.IN_B_SEL[1];
         opnd_q   <= bus.IN_B_SEL[0] ? reg_rd : bus.IMM;
         rsel_q   <= bus.REG_SEL;
         en_reg_q <= bus.EN_REG_F;
         en_mem_q <= bus.EN_D_MEM;
         en_acc_q <= bus.EN_ACC;
         addr_q   <= addr_in;
      end
   end

   // ------------------------------------------------------- data memory
   // The read is launched on the accepting edge so data is ready even when
   // MEM_LAT is 0. Reads and writes never overlap: writes happen only in EXEC.
   always_ff @(posedge CLK) begin
      if (accept && bus.IN_B_SEL[1]) begin
         mem_rd <= mem[addr_in];
      end
      if (commit && en_mem_q) begin
         mem[addr_q] <= acc;
      end
   end

   // ------------------------------------------------------------- ALU
   always_comb begin
      alu_b     = b_mem_q ? mem_rd : opnd_q;
      alu_res   = acc;
      alu_wide  = '0;
      alu_c     = 1'b0;
      alu_c_upd = 1'b0;
      case (op_q)
         ALU_PASS: alu_res = alu_b;
         ALU_ADD: begin
            alu_wide  = {1'b0, acc} + {1'b0, alu_b};
            alu_res   = alu_wide[WIDTH-1:0];
            alu_c     = alu_wide[WIDTH];
            alu_c_upd = 1'b1;
         end
         ALU_SUB: begin
            // top bit of the widened difference is the borrow (acc < b)
            alu_wide  = {1'b0, acc} - {1'b0, alu_b};
            alu_res   = alu_wide[WIDTH-1:0];
            alu_c     = alu_wide[WIDTH];
            alu_c_upd = 1'b1;
         end
         ALU_AND: alu_res = acc & alu_b;
         ALU_OR:  alu_res = acc | alu_b;
         ALU_XOR: alu_res = acc ^ alu_b;
         ALU_NOT: alu_res = ~acc;
         ALU_SHL: begin
            alu_res   = acc << 1;
            alu_c     = acc[WIDTH-1];
            alu_c_upd = 1'b1;
         end
         ALU_SHR: begin
            alu_res   = acc >> 1;
            alu_c     = acc[0];
            alu_c_upd = 1'b1;
         end
         default: alu_res = acc;
      endcase
   end

   // ------------------------------------------------------------ commit
   // Register and memory writes take acc before this edge's ALU update.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         acc    <= '0;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
         for (int unsigned i = 0; i < unsigned'(REG_COUNT); i++) begin
            regs[i] <= '0;
         end
`ifdef DATAPATH_MC_PORT_EN
         PORT_OUT <= '0;
`endif
      end else if (state == ST_EXEC) begin
         if (en_acc_q) begin
            acc    <= alu_res;
            flag_z <= (alu_res == '0);
            if (alu_c_upd) begin
               flag_c <= alu_c;
            end
         end
         if (en_reg_q && ({1'b0, rsel_q} < REG_LIMIT)) begin
            regs[rsel_q[RW-1:0]] <= acc;
`ifdef DATAPATH_MC_PORT_EN
            if (rsel_q == REG_LAST) begin
               PORT_OUT <= acc;
            end
`endif
         end
      end
   end

   // ----------------------------------------------------------- outputs
   assign bus.OP_READY = op_ready;
   assign bus.DONE     = done;
   assign bus.ACC_OUT  = acc;
   assign bus.FLAG_Z   = flag_z;
   assign bus.FLAG_C   = flag_c;

endmodule

// File: tb/tb_datapath_mc.sv
// tb_datapath_mc -- directed and randomized checks of datapath_mc against a
// behavioural model (integer arithmetic over arrays for registers/memory).
// Built with MEM_AW=4 so 8-bit addresses wrap, and MEM_LAT=2.
module tb_datapath_mc;
   localparam int WIDTH     = 8;
   localparam int REG_COUNT = 8;
   localparam int MEM_AW    = 4;
   localparam int MEM_LAT   = 2;

   logic CLK = 1'b0;
   logic RST_N = 1'b0;
   always #5 CLK = ~CLK;

   datapath_mc_if #(.WIDTH(WIDTH)) bus ();

   datapath_mc #(
      .WIDTH(WIDTH),
      .REG_COUNT(REG_COUNT),
      .MEM_AW(MEM_AW),
      .MEM_LAT(MEM_LAT)
   ) dut (
      .CLK(CLK),
      .RST_N(RST_N),
      .bus(bus)
   );

   // reference model state
   int m_acc;
   int m_z;
   int m_c;
   int m_reg [REG_COUNT];
   int m_mem [2**MEM_AW];

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_acc = 0;
      m_z   = 0;
      m_c   = 0;
      for (int i = 0; i < REG_COUNT; i++) m_reg[i] = 0;
   endtask

   function automatic int reg_value(input int idx);
      return (idx < REG_COUNT) ? m_reg[idx] : 0;
   endfunction

   // Apply one operation to the model; everything is evaluated from the
   // state before the operation, then committed together.
   task automatic model_op(input int alu, input int bsel, input int imm, input int rsel,
                           input int enr, input int enm, input int ena,
                           input int addr, input int mode);
      int a, b, r, c, eff;
      a   = m_acc;
      eff = (mode != 0 ? reg_value(rsel) : addr) % (2**MEM_AW);
      if (bsel >= 2)      b = m_mem[eff];
      else if (bsel == 1) b = reg_value(rsel);
      else                b = imm;
      c = m_c;
      case (alu)
         0: r = b;
         1: begin r = a + b; c = (r > 255) ? 1 : 0; end
         2: begin r = a - b; c = (a < b) ? 1 : 0; end
         3: r = a & b;
         4: r = a | b;
         5: r = a ^ b;
         6: r = 255 - a;
         7: begin r = a * 2; c = (a >= 128) ? 1 : 0; end
         8: begin r = a / 2; c = a % 2; end
         default: r = a;
      endcase
      r = r & 255;
      if (enr != 0 && rsel < REG_COUNT) m_reg[rsel] = a;
      if (enm != 0) m_mem[eff] = a;
      if (ena != 0) begin
         m_acc = r;
         m_z   = (r == 0) ? 1 : 0;
         m_c   = c;
      end
   endtask

   // Issue one operation from IDLE (called #1 after a rising edge), scramble
   // the inputs after acceptance, and check latency and committed results.
   task automatic run_op(input string tag, input int alu, input int bsel, input int imm,
                         input int rsel, input int enr, input int enm, input int ena,
                         input int addr, input int mode);
      int lat, exp_lat;
      check({tag, ".ready"}, {31'd0, bus.OP_READY}, 32'd1);
      bus.ALU_OP          = 4'(alu);
      bus.IN_B_SEL        = 2'(bsel);
      bus.IMM             = 8'(imm);
      bus.REG_SEL         = 4'(rsel);
      bus.EN_REG_F        = 1'(enr);
      bus.EN_D_MEM        = 1'(enm);
      bus.EN_ACC          = 1'(ena);
      bus.D_MEM_ADDR      = 8'(addr);
      bus.D_MEM_ADDR_MODE = 1'(mode);
      bus.OP_VALID        = 1'b1;
      exp_lat = (bsel >= 2) ? 1 + MEM_LAT : 1;
      model_op(alu, bsel, imm, rsel, enr, enm, ena, addr, mode);
      @(posedge CLK);
      #1;
      bus.OP_VALID        = 1'b0;
      bus.ALU_OP          = 4'($urandom);
      bus.IN_B_SEL        = 2'($urandom);
      bus.IMM             = 8'($urandom);
      bus.REG_SEL         = 4'($urandom);
      bus.EN_REG_F        = 1'($urandom);
      bus.EN_D_MEM        = 1'($urandom);
      bus.EN_ACC          = 1'($urandom);
      bus.D_MEM_ADDR      = 8'($urandom);
      bus.D_MEM_ADDR_MODE = 1'($urandom);
      lat = 1;
      while (!bus.DONE && lat < 20) begin
         @(posedge CLK);
         #1;
         lat++;
      end
      check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
      @(posedge CLK);
      #1;
      check({tag, ".acc"}, {24'd0, bus.ACC_OUT}, 32'(m_acc));
      check({tag, ".zc"}, {30'd0, bus.FLAG_Z, bus.FLAG_C}, 32'(m_z * 2 + m_c));
      check({tag, ".ready_done"}, {30'd0, bus.OP_READY, bus.DONE}, 32'd2);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int alu, bsel, en;
      bus.OP_VALID        = 1'b0;
      bus.ALU_OP          = '0;
      bus.IN_B_SEL        = '0;
      bus.IMM             = '0;
      bus.REG_SEL         = '0;
      bus.EN_REG_F        = 1'b0;
      bus.EN_D_MEM        = 1'b0;
      bus.EN_ACC          = 1'b0;
      bus.D_MEM_ADDR      = '0;
      bus.D_MEM_ADDR_MODE = 1'b0;
      model_reset();
      for (int i = 0; i < 2**MEM_AW; i++) m_mem[i] = 0;

      // reset state
      RST_N = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;
      check("reset.acc", {24'd0, bus.ACC_OUT}, 32'd0);
      check("reset.zc", {30'd0, bus.FLAG_Z, bus.FLAG_C}, 32'd0);
      check("reset.ready_done", {30'd0, bus.OP_READY, bus.DONE}, 32'd2);

      // pass immediate
      run_op("pass_imm", 0, 0, 8'h5A, 0, 0, 0, 1, 0, 0);
      check("pass_imm.val", {24'd0, bus.ACC_OUT}, 32'h5A);

      // add with carry-out to zero
      run_op("ld_ff", 0, 0, 8'hFF, 0, 0, 0, 1, 0, 0);
      run_op("add_wrap", 1, 0, 8'h01, 0, 0, 0, 1, 0, 0);
      check("add_wrap.zc_val", {30'd0, bus.FLAG_Z, bus.FLAG_C}, 32'd3);

      // fill the whole memory (addresses above 15 wrap)
      for (int i = 0; i < 2**MEM_AW; i++) begin
         run_op("fill", 0, 0, int'($urandom_range(0, 255)), 0, 0, 1, 1,
                i + 16 * int'($urandom_range(0, 15)), 0);
      end

      // store/load through wrapped address 0x10 with memory latency
      run_op("ld_33", 0, 0, 8'h33, 0, 0, 0, 1, 0, 0);
      run_op("st_10", 15, 0, 0, 0, 0, 1, 0, 8'h10, 0);
      run_op("ld_c4", 0, 0, 8'hC4, 0, 0, 0, 1, 0, 0);
      run_op("mem_ld", 0, 2, 0, 0, 0, 0, 1, 8'h10, 0);
      check("mem_ld.val", {24'd0, bus.ACC_OUT}, 32'h33);

      // register write and ACC update on the same edge
      run_op("ld_07", 0, 0, 8'h07, 0, 0, 0, 1, 0, 0);
      run_op("reg_and_acc", 1, 0, 1, 2, 1, 0, 1, 0, 0);
      check("reg_and_acc.val", {24'd0, bus.ACC_OUT}, 32'h08);
      run_op("rd_r2", 0, 1, 0, 2, 0, 0, 1, 0, 0);
      check("rd_r2.val", {24'd0, bus.ACC_OUT}, 32'h07);

      // out-of-range register: write ignored, read 0
      run_op("wr_r9", 15, 0, 0, 9, 1, 0, 0, 0, 0);
      run_op("rd_r9", 0, 1, 0, 9, 0, 0, 1, 0, 0);

      // register-indirect store while the same register is overwritten
      run_op("ld_a5", 0, 0, 8'hA5, 0, 0, 0, 1, 0, 0);
      run_op("ind_st", 15, 0, 0, 3, 1, 1, 0, 0, 1);
      run_op("ind_ld", 0, 2, 0, 3, 0, 0, 1, 0, 1);

      // reset during MEM_WAIT aborts the operation
      run_op("ld_9c", 0, 0, 8'h9C, 0, 0, 0, 1, 0, 0);
      bus.ALU_OP = 4'd0; bus.IN_B_SEL = 2'b10; bus.EN_ACC = 1'b1;
      bus.EN_REG_F = 1'b1; bus.EN_D_MEM = 1'b1; bus.REG_SEL = 4'd1;
      bus.D_MEM_ADDR = 8'h05; bus.D_MEM_ADDR_MODE = 1'b0;
      bus.OP_VALID = 1'b1;
      @(posedge CLK);
      #1;
      bus.OP_VALID = 1'b0;
      check("abort.in_wait", {30'd0, bus.OP_READY, bus.DONE}, 32'd0);
      RST_N = 1'b0;
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      model_reset();
      check("abort.acc", {24'd0, bus.ACC_OUT}, 32'd0);
      check("abort.zc", {30'd0, bus.FLAG_Z, bus.FLAG_C}, 32'd0);
      check("abort.ready_done", {30'd0, bus.OP_READY, bus.DONE}, 32'd2);
      @(posedge CLK);
      #1;
      check("abort.no_done", {30'd0, bus.OP_READY, bus.DONE}, 32'd2);
      // memory survives reset, registers do not
      run_op("post_rst_mem", 0, 2, 0, 0, 0, 0, 1, 8'h05, 0);
      run_op("post_rst_r2", 0, 1, 0, 2, 0, 0, 1, 0, 0);

      // randomized operations
      for (int n = 0; n < 200; n++) begin
         alu  = int'($urandom_range(0, 15));
         bsel = int'($urandom_range(0, 3));
         en   = int'($urandom_range(0, 7));
         run_op($sformatf("rnd%0d", n), alu, bsel, int'($urandom_range(0, 255)),
                int'($urandom_range(0, 15)), en & 1, (en >> 1) & 1, ((en >> 2) & 1) | (n % 2),
                int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
